dma_write_engine: RTL and testbench
===================================

DMA_WRITE_ENGINE -- requirements
Module: dma_write_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, power-of-2 depth of the internal line buffer (minimum 4).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port dst_addr  input  t_ccip_clAddr  destination base cache-line address, sampled on start.
REQ-005 SHALL have port dst_ncl  input  32  number of cache lines to write, sampled on start.
REQ-006 SHALL have port start  input  1  one-cycle start pulse.
REQ-007 SHALL have port in_data  input  512  line payload.
REQ-008 SHALL have port in_valid  input  1  payload valid.
REQ-009 SHALL have port in_ready  output  1  payload accepted when in_valid & in_ready.
REQ-010 SHALL have port c1TxAlmFull  input  1  c1 Tx almost-full back-pressure.
REQ-011 SHALL have port c1tx  output  t_if_ccip_c1_Tx  write request channel.
REQ-012 SHALL have port c1rx  input  t_if_ccip_c1_Rx  write response channel.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when all dst_ncl responses are received.
REQ-015 SHALL have port stall_cycles  output  32  back-pressure stall count (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE, WRITE, DRAIN, DONE; start is ignored outside IDLE.
REQ-017 In IDLE, start with dst_ncl!=0 SHALL latch dst_addr and dst_ncl, clear the accepted, issued and response counters, and enter WRITE.
REQ-018 In IDLE, start with dst_ncl==0 SHALL enter DONE directly, with no c1tx request.
REQ-019 in_ready SHALL be combinational: (state==WRITE) & FIFO not full & accepted<ncl.
REQ-020 Data beyond ncl lines SHALL NOT be accepted.
REQ-021 A line SHALL be popped when state is WRITE or DRAIN, the FIFO is non-empty, c1TxAlmFull==0, and issued<ncl.
REQ-022 c1tx SHALL be registered: the cycle after a pop, c1tx.valid=1 with address=base+issued, req_type=eREQ_WRLINE_I, vc_sel=eVC_VA, cl_len=eCL_LEN_1, sop=1, mdata=issued[15:0], rsvd=0, data=popped line; otherwise c1tx.valid=0.
REQ-023 Issue latency from acceptance into an empty FIFO with c1TxAlmFull low SHALL be 2 cycles.
REQ-024 At most one request SHALL be issued per cycle; order SHALL equal acceptance order.
REQ-025 On c1rx.rspValid with resp_type eRSP_WRLINE, the response count SHALL add 1 if hdr.format==0, else cl_num+1; a response and an issue in the same cycle SHALL both be counted.
REQ-026 Responses received in IDLE SHALL be ignored.
REQ-027 WRITE SHALL move to DRAIN when issued==ncl.
REQ-028 DRAIN SHALL move to DONE when response count==ncl, including in the cycle that the final response arrives.
REQ-029 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-030 Counters SHALL be 32-bit unsigned; address arithmetic SHALL be modulo t_ccip_clAddr width.

Reset
REQ-031 Asynchronous reset SHALL force: state IDLE; FIFO empty; all counters 0; c1tx all-zero; in_ready 0; busy 0; done 0; stall_cycles 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no further requests; late responses arrive in IDLE and SHALL be ignored.

Configuration
REQ-033 With DMA_WRITE_STALL_CNT_EN defined, stall_cycles SHALL increment (saturating at 2^32-1) every cycle in WRITE/DRAIN in which the FIFO is non-empty and c1TxAlmFull==1, and SHALL clear on an accepted start.
REQ-034 Without DMA_WRITE_STALL_CNT_EN, stall_cycles SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-035 start, dst_addr=0x1000, dst_ncl=4, 4 lines streamed, immediate responses -> requests at addresses 0x1000..0x1003 with mdata 0..3, one done pulse, busy falls the same cycle.
REQ-036 dst_ncl=8, c1TxAlmFull held high for 10 cycles after the first accept -> no c1tx.valid during the hold, in_ready low once 16 lines are buffered or all 8 accepted, all 8 issued in order after release; stall_cycles=10 with the macro, 0 without.
REQ-037 dst_ncl=2, 3 lines offered -> only 2 accepted, third stays pending with in_ready=0.
REQ-038 dst_ncl=4, responses returned as a single packed response with format=1, cl_num=eCL_LEN_4 -> DONE reached, done pulses once.
REQ-039 dst_ncl=0 start -> done pulse 2 cycles after start, zero c1tx.valid.
REQ-040 reset pulsed after 2 of 6 lines issued, then 4 responses injected -> state IDLE, no requests, no done; a new start with dst_ncl=1 completes normally.

Source files
------------

// File: rtl/dma_write_engine.sv
// dma_write_engine
// Streams dst_ncl cache lines from a valid/ready input into CCI-P c1 write
// requests (WrLine_I, VA channel, one line per request) at dst_addr onward,
// then waits for the matching write responses before pulsing done.
//
// c1tx / c1rx are flat vectors with the packed CCI-P layout:
//   c1tx[592:0] = {hdr[79:0], data[511:0], valid}
//     hdr = {rsvd2[5:0], vc_sel[1:0], sop, rsvd1, cl_len[1:0],
//            req_type[3:0], rsvd0[5:0], address[41:0], mdata[15:0]}
//   c1rx[28:0]  = {hdr[27:0], rspValid}
//     hdr = {vc_used[1:0], rsvd1, hit_miss, format, rsvd0,
//            cl_num[1:0], resp_type[3:0], mdata[15:0]}
//
// Build option: DMA_WRITE_STALL_CNT_EN adds a saturating counter of cycles
// where buffered lines were held back by c1TxAlmFull. When it is undefined,
// stall_cycles is tied to zero.
//
// FIFO_DEPTH must be a power of two, 4 or more.
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | accepting input lines and issuing write requests
// DRAIN  | every request issued, waiting for the remaining responses
// DONE   | transfer complete, done pulses on the following cycle

module dma_write_engine #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [41:0]  dst_addr,
    input  logic [31:0]  dst_ncl,
    input  logic         start,
    input  logic [511:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         c1TxAlmFull,
    output logic [592:0] c1tx,
    input  logic [28:0]  c1rx,
    output logic         busy,
    output logic         done,
    output logic [31:0]  stall_cycles
);

    localparam int CL_ADDR_W = 42;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);

    localparam logic [3:0] REQ_WRLINE_I = 4'h1;
    localparam logic [1:0] VC_VA        = 2'h0;
    localparam logic [1:0] CL_LEN_1     = 2'h0;
    localparam logic [3:0] RSP_WRLINE   = 4'h1;

    typedef struct packed {
        logic [5:0]           rsvd2;
        logic [1:0]           vc_sel;
        logic                 sop;
        logic                 rsvd1;
        logic [1:0]           cl_len;
        logic [3:0]           req_type;
        logic [5:0]           rsvd0;
        logic [CL_ADDR_W-1:0] address;
        logic [15:0]          mdata;
    } t_c1_req_hdr;

    typedef struct packed {
        t_c1_req_hdr  hdr;
        logic [511:0] data;
        logic         valid;
    } t_c1_tx;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_c1_rsp_hdr;

    typedef struct packed {
        t_c1_rsp_hdr hdr;
        logic        rspValid;
    } t_c1_rx;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } t_state;

    t_state               state;
    logic [CL_ADDR_W-1:0] base_addr;
    logic [31:0]          ncl;
    logic [31:0]          acc_cnt;
    logic [31:0]          iss_cnt;
    logic [31:0]          rsp_cnt;
    t_c1_tx               c1tx_q;
    logic                 done_q;

    logic [511:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr;
    logic [PTR_W:0]       rd_ptr;
    logic                 fifo_empty;
    logic                 fifo_full;

    t_c1_rx               rx;
    logic                 accept;
    logic                 pop;
    logic                 xfer_active;
    logic                 rsp_hit;
    logic [31:0]          rsp_inc;
    logic [31:0]          rsp_next;
    logic                 unused_rx;

    assign rx = c1rx;

    // Only the header fields that carry the line count matter here.
    assign unused_rx = &{1'b0, rx.hdr.vc_used, rx.hdr.rsvd1, rx.hdr.hit_miss,
                         rx.hdr.rsvd0, rx.hdr.mdata};

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign xfer_active = (state == ST_WRITE) || (state == ST_DRAIN);

    assign in_ready    = (state == ST_WRITE) && !fifo_full && (acc_cnt < ncl);
    assign accept      = in_valid && in_ready;
    assign pop         = xfer_active && !fifo_empty && !c1TxAlmFull && (iss_cnt < ncl);

    // A packed response (format=1) covers cl_num+1 lines.
    assign rsp_hit  = rx.rspValid && (rx.hdr.resp_type == RSP_WRLINE) && (state != ST_IDLE);
    assign rsp_inc  = rx.hdr.format ? ({30'd0, rx.hdr.cl_num} + 32'd1) : 32'd1;
    assign rsp_next = rsp_hit ? (rsp_cnt + rsp_inc) : rsp_cnt;

    assign c1tx = c1tx_q;
    assign busy = (state != ST_IDLE);
    assign done = done_q;

    // Line buffer storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= in_data;
        end
    end

    // Line buffer pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Transfer FSM, counters and the registered c1 request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_addr <= '0;
            ncl       <= '0;
            acc_cnt   <= '0;
            iss_cnt   <= '0;
            rsp_cnt   <= '0;
            c1tx_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q       <= (state == ST_DONE);
            c1tx_q.valid <= 1'b0;

            if (accept) begin
                acc_cnt <= acc_cnt + 32'd1;
            end

            if (pop) begin
                iss_cnt               <= iss_cnt + 32'd1;
                c1tx_q.valid          <= 1'b1;
                c1tx_q.data           <= fifo_mem[rd_ptr[PTR_W-1:0]];
                c1tx_q.hdr.rsvd2      <= '0;
                c1tx_q.hdr.vc_sel     <= VC_VA;
                c1tx_q.hdr.sop        <= 1'b1;
                c1tx_q.hdr.rsvd1      <= 1'b0;
                c1tx_q.hdr.cl_len     <= CL_LEN_1;
                c1tx_q.hdr.req_type   <= REQ_WRLINE_I;
                c1tx_q.hdr.rsvd0      <= '0;
                c1tx_q.hdr.address    <= base_addr + {{(CL_ADDR_W-32){1'b0}}, iss_cnt};
                c1tx_q.hdr.mdata      <= iss_cnt[15:0];
            end

            if (rsp_hit) begin
                rsp_cnt <= rsp_next;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (dst_ncl != 32'd0) begin
                            base_addr <= dst_addr;
                            ncl       <= dst_ncl;
                            acc_cnt   <= '0;
                            iss_cnt   <= '0;
                            rsp_cnt   <= '0;
                            state     <= ST_WRITE;
                        end else begin
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (iss_cnt == ncl) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rsp_next == ncl) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMA_WRITE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count cycles where buffered lines were blocked by c1 almost-full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state == ST_IDLE) && start) begin
            stall_q <= '0;
        end else if (xfer_active && !fifo_empty && c1TxAlmFull && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_write_engine.sv
// Self-checking bench for dma_write_engine: expected write requests are
// queued as input lines are accepted and compared as c1tx requests appear.

module tb_dma_write_engine;

    localparam int FIFO_DEPTH = 16;

    logic         clk;
    logic         reset;
    logic [41:0]  dst_addr;
    logic [31:0]  dst_ncl;
    logic         start;
    logic [511:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         c1TxAlmFull;
    logic [592:0] c1tx;
    logic [28:0]  c1rx;
    logic         busy;
    logic         done;
    logic [31:0]  stall_cycles;

    dma_write_engine #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .dst_addr     (dst_addr),
        .dst_ncl      (dst_ncl),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .c1TxAlmFull  (c1TxAlmFull),
        .c1tx         (c1tx),
        .c1rx         (c1rx),
        .busy         (busy),
        .done         (done),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [41:0]  addr;
        logic [15:0]  mdata;
        logic [511:0] data;
    } t_exp;

    localparam logic [21:0] EXP_CTL = {6'd0, 2'b00, 1'b1, 1'b0, 2'b00, 4'h1, 6'd0};

    int          checks;
    int          failures;
    t_exp        sb_q[$];
    int          tx_cyc_q[$];
    t_exp        mon_e;
    logic [41:0] cur_base;
    int          acc_idx;
    int          first_acc_cyc;
    int          tx_count;
    int          done_count;
    int          cyc;
    bit          auto_rsp;
    int          man_req;
    int          man_ack;
    logic        man_fmt;
    logic [1:0]  man_cl;
    int          test_id;
    int          tx_base;
    int          dc0;
    int          n;
    logic [63:0] exp_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input int tid, input int i);
        logic [511:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*64 +: 64] = {16'(k), 16'(tid), 32'(i)};
        end
        return d;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Request monitor, scoreboard compare and response generator.
    initial begin
        c1rx = '0;
        forever begin
            @(negedge clk);
            c1rx = '0;
            if (reset !== 1'b0) continue;
            if (done) done_count++;
            if (c1tx[0]) begin
                tx_count++;
                tx_cyc_q.push_back(cyc);
                if (sb_q.size() == 0) begin
                    chk("tx_unexpected", 64'(c1tx[570:529]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("tx_addr",    64'(c1tx[570:529]), 64'(mon_e.addr));
                    chk("tx_mdata",   64'(c1tx[528:513]), 64'(mon_e.mdata));
                    chk("tx_data_lo", c1tx[64:1],         mon_e.data[63:0]);
                    chk("tx_data_hi", c1tx[512:449],      mon_e.data[511:448]);
                    chk("tx_ctl",     64'(c1tx[592:571]), 64'(EXP_CTL));
                end
                if (auto_rsp) begin
                    c1rx = {2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h1, c1tx[528:513], 1'b1};
                end
            end
            if (!c1rx[0] && (man_ack < man_req)) begin
                c1rx = {2'b00, 1'b0, 1'b0, man_fmt, 1'b0, man_cl, 4'h1, 16'h0, 1'b1};
                man_ack++;
            end
        end
    end

    task automatic do_start(input logic [41:0] base, input logic [31:0] ncl_v);
        cur_base = base;
        acc_idx  = 0;
        @(posedge clk); #1;
        dst_addr = base;
        dst_ncl  = ncl_v;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic feed(input int cnt);
        t_exp e;
        for (int i = 0; i < cnt; i++) begin
            int  w;
            bit  ok;
            w  = 0;
            ok = 0;
            in_data  = line_data(test_id, i);
            in_valid = 1'b1;
            while (!ok && w < 200) begin
                @(negedge clk);
                if (in_ready) begin
                    e.addr  = cur_base + 42'(acc_idx);
                    e.mdata = 16'(acc_idx);
                    e.data  = in_data;
                    sb_q.push_back(e);
                    if (acc_idx == 0) first_acc_cyc = cyc;
                    acc_idx++;
                    ok = 1;
                end
                w++;
                @(posedge clk); #1;
            end
            if (!ok) chk("feed_timeout", 64'(i), 64'hFFFF_FFFF);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int   k;
        bit   seen;
        logic prev_busy;
        k         = 0;
        seen      = 0;
        prev_busy = busy;
        while (!seen && k < budget) begin
            @(negedge clk);
            k++;
            if (done) begin
                seen = 1;
                chk({tag, "_busy_before_done"}, 64'(prev_busy), 64'd1);
                chk({tag, "_busy_fall"},        64'(busy),      64'd0);
            end
            prev_busy = busy;
        end
        if (!seen) begin
            chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            @(negedge clk);
            chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        dst_addr    = '0;
        dst_ncl     = '0;
        start       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        c1TxAlmFull = 1'b0;
        auto_rsp    = 1'b0;
        man_req     = 0;
        man_fmt     = 1'b0;
        man_cl      = 2'b00;
        test_id     = 0;
        acc_idx     = 0;
`ifdef DMA_WRITE_STALL_CNT_EN
        exp_stall = 64'd10;
`else
        exp_stall = 64'd0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_c1tx_zero", 64'(|c1tx),    64'd0);
        chk("rst_in_ready",  64'(in_ready), 64'd0);
        chk("rst_busy",      64'(busy),     64'd0);
        chk("rst_done",      64'(done),     64'd0);
        chk("rst_stall",     64'(stall_cycles), 64'd0);
        reset = 1'b0;

        // Basic 4-line transfer with immediate responses
        test_id  = 1;
        auto_rsp = 1'b1;
        tx_base  = tx_count;
        dc0      = done_count;
        do_start(42'h1000, 32'd4);
        feed(4);
        wait_done("t1", 100);
        chk("t1_tx_count",   64'(tx_count - tx_base), 64'd4);
        chk("t1_latency",    64'(tx_cyc_q[tx_base] - first_acc_cyc), 64'd2);
        chk("t1_done_count", 64'(done_count - dc0), 64'd1);
        chk("t1_sb_empty",   64'(sb_q.size()), 64'd0);

        // Almost-full held for 10 cycles after the first accept
        test_id     = 2;
        c1TxAlmFull = 1'b1;
        tx_base     = tx_count;
        dc0         = done_count;
        do_start(42'h2000, 32'd8);
        fork
            feed(8);
            begin : hold
                int h;
                h = 0;
                while (acc_idx == 0 && h < 100) begin
                    @(posedge clk);
                    h++;
                end
                repeat (10) @(posedge clk);
                #1;
                chk("t2_no_tx_during_hold", 64'(tx_count - tx_base), 64'd0);
                chk("t2_in_ready_low",      64'(in_ready), 64'd0);
                chk("t2_all_accepted",      64'(acc_idx),  64'd8);
                c1TxAlmFull = 1'b0;
            end
        join
        wait_done("t2", 200);
        chk("t2_tx_count", 64'(tx_count - tx_base), 64'd8);
        chk("t2_stall",    64'(stall_cycles), exp_stall);
        chk("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // Over-offer: ncl=2, third line must stay pending; address wraps
        test_id = 3;
        tx_base = tx_count;
        do_start(42'h3FF_FFFF_FFFF, 32'd2);
        feed(2);
        in_data  = line_data(test_id, 2);
        in_valid = 1'b1;
        @(negedge clk);
        chk("t3_third_blocked", 64'(in_ready), 64'd0);
        wait_done("t3", 100);
        chk("t3_tx_count", 64'(tx_count - tx_base), 64'd2);
        in_valid = 1'b0;
        chk("t3_sb_empty", 64'(sb_q.size()), 64'd0);

        // Single packed response covering four lines
        test_id  = 4;
        auto_rsp = 1'b0;
        tx_base  = tx_count;
        dc0      = done_count;
        do_start(42'h4000, 32'd4);
        feed(4);
        n = 0;
        while ((tx_count - tx_base) < 4 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t4_no_early_done", 64'(done_count - dc0), 64'd0);
        chk("t4_busy_waiting",  64'(busy), 64'd1);
        man_fmt = 1'b1;
        man_cl  = 2'b11;
        man_req++;
        wait_done("t4", 50);
        chk("t4_done_count", 64'(done_count - dc0), 64'd1);

        // Zero-length start
        test_id = 5;
        tx_base = tx_count;
        @(posedge clk); #1;
        dst_ncl = 32'd0;
        start   = 1'b1;
        @(negedge clk);
        chk("t5_done_c0", 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("t5_done_c1", 64'(done), 64'd0);
        chk("t5_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t5_done_c2", 64'(done), 64'd1);
        chk("t5_busy_c2", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t5_done_c3", 64'(done), 64'd0);
        chk("t5_no_tx",   64'(tx_count - tx_base), 64'd0);

        // Reset mid-transfer after two requests, then late responses
        test_id     = 6;
        auto_rsp    = 1'b0;
        c1TxAlmFull = 1'b1;
        tx_base     = tx_count;
        dc0         = done_count;
        do_start(42'h6000, 32'd6);
        feed(6);
        c1TxAlmFull = 1'b0;
        n = 0;
        while ((tx_count - tx_base) < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        reset = 1'b1;
        sb_q.delete();
        #1;
        chk("t6_rst_c1tx",     64'(|c1tx),    64'd0);
        chk("t6_rst_busy",     64'(busy),     64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        chk("t6_rst_stall",    64'(stall_cycles), 64'd0);
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        man_fmt = 1'b0;
        man_cl  = 2'b00;
        man_req = man_req + 4;
        repeat (10) @(negedge clk);
        chk("t6_tx_after_rst", 64'(tx_count - tx_base), 64'd2);
        chk("t6_no_done",      64'(done_count - dc0),   64'd0);
        chk("t6_idle",         64'(busy), 64'd0);

        test_id  = 7;
        auto_rsp = 1'b1;
        tx_base  = tx_count;
        dc0      = done_count;
        do_start(42'h7000, 32'd1);
        feed(1);
        wait_done("t7", 100);
        chk("t7_tx_count",   64'(tx_count - tx_base), 64'd1);
        chk("t7_done_count", 64'(done_count - dc0),   64'd1);
        chk("t7_sb_empty",   64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
